store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/y86_mem_pkg.sv | 12 +
 rtl/store_fifo.sv | 67 ++++++
 rtl/store_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared data-memory sizing and address legality check
package y86_mem_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  // Word address 0 is reserved as a fault trap; everything at or above the bound is unmapped
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] words);
    return (addr != 64'd0) && (addr < words);
  endfunction

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - circular store queue with youngest-match address search
module store_fifo
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic [63:0]               i_push_addr,
  input  logic signed [63:0]        i_push_data,
  input  logic                      i_pop,
  input  logic [63:0]               i_search_addr,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [63:0]               o_head_addr,
  output logic signed [63:0]        o_head_data,
  output logic                      o_hit,
  output logic signed [63:0]        o_hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]        r_addr [DEPTH];
  logic signed [63:0] r_data [DEPTH];
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;

  // Entry storage is written at the tail; stale slots are never read because count bounds the search
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; push and pop together leave count alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(i_pop);
      r_tail  <= r_tail + PW'(i_push);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store to that address
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_addr[r_head + PW'(k)] == i_search_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[r_head + PW'(k)];
      end
    end
  end

  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - memory-stage store buffer with load forwarding and background drain
module store_buffer
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [63:0]        req_addr,
  input  logic signed [63:0] req_data,
  output logic               req_ready,
  output logic               resp_valid,
  output logic signed [63:0] resp_data,
  output logic               resp_error,
  output logic [63:0]        mem_address,
  output logic               mem_write_enable,
  output logic signed [63:0] mem_data_in,
  input  logic signed [63:0] mem_data_out,
  input  logic               mem_error,
  output logic               sb_empty,
  output logic               sticky_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      w_count;
  logic [63:0]        w_head_addr;
  logic signed [63:0] w_head_data;
  logic               w_hit;
  logic signed [63:0] w_hit_data;
  logic               w_legal;
  logic               w_accept;
  logic               w_push;
  logic               w_load_hit;
  logic               w_load_miss;
  logic               w_drain;

  logic               r_resp_valid;
  logic signed [63:0] r_resp_data;
  logic               r_resp_error;
  logic               r_sticky_err;

  assign w_legal     = addr_legal(req_addr, 64'(MEM_WORDS));
  // Loads never occupy a slot, so only a store can be stalled by a full buffer
  assign req_ready   = !reset && (!req_write || (w_count < CW'(DEPTH)));
  assign w_accept    = req_valid && req_ready;
  assign w_push      = w_accept && req_write && w_legal;
  assign w_load_hit  = w_accept && !req_write && w_legal && w_hit;
  assign w_load_miss = w_accept && !req_write && w_legal && !w_hit;
  // A load miss owns the single memory port this cycle; the drain simply retries next cycle
  assign w_drain     = !reset && (w_count != '0) && !w_load_miss;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_addr   (req_addr),
    .i_push_data   (req_data),
    .i_pop         (w_drain),
    .i_search_addr (req_addr),
    .o_count       (w_count),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

  // Memory port mux: load miss read, else head drain, else parked at address 0
  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_data_in      = '0;
    if (w_load_miss) begin
      mem_address = req_addr;
    end else if (w_drain) begin
      mem_address      = w_head_addr;
      mem_write_enable = 1'b1;
      mem_data_in      = w_head_data;
    end
  end

  // One response per accepted request; miss data is captured as memory returns it at this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_error <= w_accept && !w_legal;
      if (w_load_miss) begin
        r_resp_data <= mem_data_out;
      end else if (w_load_hit) begin
        r_resp_data <= w_hit_data;
      end else begin
        r_resp_data <= '0;
      end
    end
  end

  // Memory faults only count when the port actually carried an access this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_err <= 1'b0;
    end else if ((w_load_miss || w_drain) && mem_error) begin
      r_sticky_err <= 1'b1;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_error = r_resp_error;
  assign sticky_err = r_sticky_err;
  assign sb_empty   = (w_count == '0);

endmodule
